// File: rtl/alu_op_sequencer.sv
// Byte-serial opcode/A/B loader that drives an 8-bit ALU and holds its result until accepted.
// Optional macro ALU_SEQ_CHAIN_EN: opcode bit 7 reuses the last result as operand A.
module alu_op_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [7:0]       alu_result,
    output logic [7:0]       res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_LOAD_OP,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [7:0]       r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_handshake;
    logic             w_chain;

`ifdef ALU_SEQ_CHAIN_EN
    assign w_chain = in_data[7];
`else
    assign w_chain = 1'b0;
`endif

    assign in_ready    = (r_state == S_LOAD_OP) || (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign res_valid   = (r_state == S_HOLD);
    assign busy        = (r_state != S_LOAD_OP);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = res_valid && res_ready;

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_sel  = r_op;
    assign res_data = r_res;
    assign op_count = r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD_OP: if (w_accept) w_next = w_chain ? S_LOAD_B : S_LOAD_A;
            S_LOAD_A:  if (w_accept) w_next = S_LOAD_B;
            S_LOAD_B:  if (w_accept) w_next = S_EXEC;
            S_EXEC:    w_next = S_HOLD;
            S_HOLD:    if (w_handshake) w_next = S_LOAD_OP;
            default:   w_next = S_LOAD_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD_OP;
        end else begin
            r_state <= w_next;
        end
    end

    // Chaining copies the held result into A on the same edge the opcode is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    S_LOAD_OP: begin
                        r_op <= in_data[1:0];
                        if (w_chain) r_a <= r_res;
                    end
                    S_LOAD_A: r_a <= in_data;
                    S_LOAD_B: r_b <= in_data;
                    default:  ;
                endcase
            end
            if (r_state == S_EXEC) r_res <= alu_result;
            if (w_handshake) r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a stand-in ALU and a transaction-level model.
// Expectations follow ALU_SEQ_CHAIN_EN when the macro is defined for the build.
module tb_alu_op_sequencer;

    localparam int CNT_W = 8;
`ifdef ALU_SEQ_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [1:0]       alu_sel;
    logic [7:0]       alu_result;
    logic [7:0]       res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int               vectors = 0;
    int               miscompares = 0;
    int               cycleCnt = 0;
    logic [CNT_W-1:0] mCount;
    logic [7:0]       mLast;

    alu_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Stand-in for the combinational ALU instance.
    always_comb begin
        case (alu_sel)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    function automatic logic [7:0] aluRef(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (sel)
            2'd0:    r = (int'(a) + int'(b)) % 256;
            2'd1:    r = (int'(a) - int'(b) + 256) % 256;
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 8'(r);
    endfunction

    task automatic resetDut();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mCount = '0;
        mLast = 8'h00;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int waitCnt;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_data = b;
        in_valid = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL in_ready_timeout actual=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    // Runs EXEC and HOLD after the B byte, checking flags, operands and the held result.
    task automatic finishTxn(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b, input int readyDelay);
        logic [7:0] expRes;
        expRes = aluRef(sel, a, b);
        res_ready = (readyDelay == 0);
        @(negedge clk);
        vectors++;
        if ({in_ready, res_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL exec_flags actual ready/valid/busy=%b required=001", {in_ready, res_valid, busy});
        end
        vectors++;
        if ({alu_sel, alu_a, alu_b} !== {sel, a, b}) begin
            miscompares++;
            $display("[TB] FAIL exec_operands actual sel=%0d a=%h b=%h required sel=%0d a=%h b=%h",
                     alu_sel, alu_a, alu_b, sel, a, b);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== expRes) begin
                miscompares++;
                $display("[TB] FAIL hold_wait actual valid=%b ready=%b data=%h required valid=1 ready=0 data=%h",
                         res_valid, in_ready, res_data, expRes);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== expRes) begin
            miscompares++;
            $display("[TB] FAIL hold_result actual valid=%b data=%h required valid=1 data=%h", res_valid, res_data, expRes);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        mCount = mCount + 1'b1;
        mLast = expRes;
        vectors++;
        if ({res_valid, in_ready, busy} !== 3'b010 || op_count !== mCount || res_data !== expRes) begin
            miscompares++;
            $display("[TB] FAIL after_handshake actual valid/ready/busy=%b count=%0d data=%h required 010 count=%0d data=%h",
                     {res_valid, in_ready, busy}, op_count, res_data, mCount, expRes);
        end
    endtask

    task automatic doTxn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int gap, input int readyDelay, output int cycles);
        logic [7:0] effA;
        int t0;
        t0 = cycleCnt;
        sendByte(op, gap);
        if (CHAIN && op[7]) begin
            effA = mLast;
        end else begin
            sendByte(a, gap);
            effA = a;
        end
        sendByte(b, gap);
        finishTxn(op[1:0], effA, b, readyDelay);
        cycles = cycleCnt - t0;
    endtask

    task automatic test_reset();
        resetDut();
        vectors++;
        if ({in_ready, res_valid, busy} !== 3'b100 || res_data !== 8'h00 || op_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags actual ready/valid/busy=%b data=%h count=%0d required 100 data=00 count=0",
                     {in_ready, res_valid, busy}, res_data, op_count);
        end
        vectors++;
        if ({alu_sel, alu_a, alu_b} !== 18'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_operands actual sel=%0d a=%h b=%h required all zero", alu_sel, alu_a, alu_b);
        end
    endtask

    task automatic test_basic();
        int cyc;
        doTxn(8'h00, 8'h05, 8'h03, 0, 0, cyc);
        vectors++;
        if (cyc !== 5 || op_count !== 8'd1 || res_data !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL basic_txn actual cycles=%0d count=%0d data=%h required cycles=5 count=1 data=08",
                     cyc, op_count, res_data);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        doTxn(8'h01, 8'h03, 8'h05, 0, 10, cyc);
        vectors++;
        if (res_data !== 8'hFE || op_count !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL backpressure actual data=%h count=%0d required data=FE count=2", res_data, op_count);
        end
    endtask

    task automatic test_valid_toggle();
        int cyc;
        doTxn(8'h02, 8'hF0, 8'h3C, 1, 0, cyc);
        vectors++;
        if (res_data !== 8'h30) begin
            miscompares++;
            $display("[TB] FAIL valid_toggle actual data=%h required data=30", res_data);
        end
    endtask

    task automatic test_reset_midload();
        int cyc;
        sendByte(8'h03, 0);
        sendByte(8'hAA, 0);
        vectors++;
        if ({in_ready, busy} !== 2'b11 || alu_a !== 8'hAA) begin
            miscompares++;
            $display("[TB] FAIL midload_state actual ready/busy=%b a=%h required 11 a=AA", {in_ready, busy}, alu_a);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mCount = '0;
        mLast = 8'h00;
        vectors++;
        if ({in_ready, res_valid, busy} !== 3'b100 || res_data !== 8'h00 || op_count !== '0 ||
            {alu_sel, alu_a, alu_b} !== 18'd0) begin
            miscompares++;
            $display("[TB] FAIL midload_reset actual ready/valid/busy=%b data=%h count=%0d sel=%0d a=%h b=%h required 100 and zeros",
                     {in_ready, res_valid, busy}, res_data, op_count, alu_sel, alu_a, alu_b);
        end
        doTxn(8'h03, 8'h0F, 8'hF0, 0, 0, cyc);
        vectors++;
        if (res_data !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL midload_fresh actual data=%h required data=FF", res_data);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int n = 0; n < 24; n++) begin
            doTxn(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), cyc);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        resetDut();
        for (int n = 0; n < 256; n++) begin
            doTxn(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, cyc);
            if (n == 254) begin
                vectors++;
                if (op_count !== 8'hFF) begin
                    miscompares++;
                    $display("[TB] FAIL count_max actual=%0d required=255", op_count);
                end
            end
        end
        vectors++;
        if (op_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL count_wrap actual=%0d required=0", op_count);
        end
    endtask

    task automatic test_chain();
        int cyc;
        doTxn(8'h00, 8'h10, 8'h01, 0, 0, cyc);
`ifdef ALU_SEQ_CHAIN_EN
        doTxn(8'h80, 8'h00, 8'h02, 0, 0, cyc);
        vectors++;
        if (res_data !== 8'h13 || cyc !== 4) begin
            miscompares++;
            $display("[TB] FAIL chain_txn actual data=%h cycles=%0d required data=13 cycles=4", res_data, cyc);
        end
`else
        sendByte(8'h80, 0);
        sendByte(8'h02, 0);
        vectors++;
        if ({in_ready, busy, res_valid} !== 3'b110 || alu_a !== 8'h02 || alu_sel !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL nochain_wait actual ready/busy/valid=%b a=%h sel=%0d required 110 a=02 sel=0",
                     {in_ready, busy, res_valid}, alu_a, alu_sel);
        end
        sendByte(8'h05, 0);
        finishTxn(2'd0, 8'h02, 8'h05, 0);
        vectors++;
        if (res_data !== 8'h07) begin
            miscompares++;
            $display("[TB] FAIL nochain_result actual data=%h required data=07", res_data);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        res_ready = 1'b0;
        mCount = '0;
        mLast = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_toggle();
        test_reset_midload();
        test_random();
        test_chain();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
